// File: rtl/rx_comma_align.sv
// rx_comma_align
// -----------------------------------------------------------------------------
// Word alignment for one Timepix3 8b/10b serial link.
//
// Raw 10-bit words from the deserializer are joined with the previous word to
// form a 20-bit window. The block searches that window for the K28.5 comma
// (either running disparity) at each of the ten possible bit offsets. It then
// barrel-shifts the stream so that symbols land on 10-bit boundaries.
//
// Sync FSM:
//   HUNT   -> VERIFY : a comma is seen at any offset.
//   VERIFY -> LOCKED : enough commas are seen at the same offset.
//   LOCKED -> HUNT   : decoder errors or misplaced commas pile up.
//
// Ports
//   WCLK            in   word clock, rising edge
//   RESET           in   synchronous, active-high reset
//   i_din[9:0]      in   raw deserializer word, bit 0 received first
//   i_din_valid     in   i_din carries a new word this cycle
//   i_code_err      in   decoder error for the symbol currently on o_dout
//   o_dout[9:0]     out  aligned symbol, bit 0 = bit a
//   o_dout_valid    out  new aligned symbol while LOCKED
//   o_sync_ready    out  block is LOCKED
//   o_align_pos     out  bit offset in use (0..9)
//   o_comma_det     out  comma found at o_align_pos in the symbol on o_dout
//   o_lock_loss_cnt out  saturating count of LOCKED->HUNT transitions
// -----------------------------------------------------------------------------
module rx_comma_align #(
  parameter int COMMA_LOCK_CNT = 4,  // 2..15
  parameter int ERR_UNLOCK_CNT = 8   // 1..255
) (
  input  logic       WCLK,
  input  logic       RESET,
  input  logic [9:0] i_din,
  input  logic       i_din_valid,
  input  logic       i_code_err,
  output logic [9:0] o_dout,
  output logic       o_dout_valid,
  output logic       o_sync_ready,
  output logic [3:0] o_align_pos,
  output logic       o_comma_det,
  output logic [7:0] o_lock_loss_cnt
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [9:0]  r_prev;
  logic [3:0]  r_align_pos;
  logic [3:0]  w_align_next;
  logic [3:0]  r_hit_cnt;
  logic [3:0]  w_hit_next;
  logic [7:0]  r_err_cnt;
  logic [7:0]  w_err_next;
  logic [7:0]  r_lock_loss_cnt;
  logic [7:0]  w_lock_loss_next;

  logic [9:0]  r_dout;
  logic [9:0]  w_dout_next;
  logic        r_dout_valid;
  logic        w_dout_valid_next;
  logic        r_comma_det;
  logic        w_comma_det_next;
  logic        r_sync_ready;

  logic [19:0] w_window;
  logic [9:0]  w_match;
  logic [9:0]  w_cand [10];
  logic [3:0]  w_comma_pos;
  logic        w_comma_any;
  logic        w_comma_at_align;
  logic        w_hit_done;
  logic        w_lock_err;
  logic [8:0]  w_err_sum;
  logic        w_unlock;

  // ---------------------------------------------------------------------------
  // Comma search and barrel shifter over the 20-bit window
  // ---------------------------------------------------------------------------
  assign w_window = {i_din, r_prev};

  // Only bits a..g are compared. They carry the comma in both disparities:
  //   0011111 (RD-) and 1100000 (RD+).
  for (genvar gi = 0; gi < 10; gi++) begin : g_offset
    assign w_match[gi] = (w_window[gi+6:gi] == 7'b1111100) ||
                         (w_window[gi+6:gi] == 7'b0000011);
    assign w_cand[gi]  = w_window[gi+9:gi];
  end

  // The lowest matching offset wins.
  always_comb begin
    w_comma_pos = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (w_match[k]) begin
        w_comma_pos = 4'(k);
      end
    end
  end

  assign w_comma_any      = |w_match;
  assign w_comma_at_align = w_match[r_align_pos];

  // The current comma is the one that completes the lock count.
  assign w_hit_done = ({1'b0, r_hit_cnt} + 5'd1) == 5'(COMMA_LOCK_CNT);

  // Error sources in LOCKED:
  //   - a comma at a foreign offset;
  //   - a decoder error on a delivered symbol.
  // If both occur in the same cycle they count once.
  assign w_lock_err = (w_comma_any && !w_comma_at_align) ||
                      (i_code_err && r_dout_valid);

  // A good comma restarts the count before this cycle's error is added.
  assign w_err_sum = (w_comma_at_align ? 9'd0 : {1'b0, r_err_cnt}) +
                     {8'd0, w_lock_err};

  assign w_unlock = w_lock_err && (w_err_sum >= 9'(ERR_UNLOCK_CNT));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge WCLK) begin
    if (RESET) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // Transitions happen only on words that are actually present.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (i_din_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (w_comma_any) begin
            w_state_next = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (w_comma_at_align && w_hit_done) begin
            w_state_next = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_unlock) begin
            w_state_next = ST_HUNT;
          end
        end
        default: w_state_next = ST_HUNT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    w_align_next     = r_align_pos;
    w_hit_next       = r_hit_cnt;
    w_err_next       = r_err_cnt;
    w_lock_loss_next = r_lock_loss_cnt;
    if (i_din_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (w_comma_any) begin
            w_align_next = w_comma_pos;
            w_hit_next   = 4'd1;
          end
        end
        ST_VERIFY: begin
          if (w_comma_at_align) begin
            if (r_hit_cnt != 4'hF) begin
              w_hit_next = r_hit_cnt + 4'd1;
            end
            if (w_hit_done) begin
              w_err_next = 8'd0;
            end
          end else if (w_comma_any) begin
            // Commas moved: restart verification at the new offset.
            w_align_next = w_comma_pos;
            w_hit_next   = 4'd1;
          end
        end
        ST_LOCKED: begin
          if (w_unlock) begin
            w_align_next = 4'd0;
            w_err_next   = 8'd0;
            if (r_lock_loss_cnt != 8'hFF) begin
              w_lock_loss_next = r_lock_loss_cnt + 8'd1;
            end
          end else begin
            w_err_next = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Symbols are shifted with the offset in use before this word.
  // This applies in every state, so the lock word itself comes out aligned.
  always_comb begin
    w_dout_next       = r_dout;
    w_dout_valid_next = 1'b0;
    w_comma_det_next  = 1'b0;
    if (i_din_valid) begin
      w_dout_next       = w_cand[r_align_pos];
      w_dout_valid_next = (w_state_next == ST_LOCKED);
      w_comma_det_next  = w_comma_at_align;
    end
  end

  always_ff @(posedge WCLK) begin
    if (RESET) begin
      r_prev          <= 10'd0;
      r_align_pos     <= 4'd0;
      r_hit_cnt       <= 4'd0;
      r_err_cnt       <= 8'd0;
      r_lock_loss_cnt <= 8'd0;
      r_dout          <= 10'd0;
      r_dout_valid    <= 1'b0;
      r_comma_det     <= 1'b0;
      r_sync_ready    <= 1'b0;
    end else begin
      if (i_din_valid) begin
        r_prev <= i_din;
      end
      r_align_pos     <= w_align_next;
      r_hit_cnt       <= w_hit_next;
      r_err_cnt       <= w_err_next;
      r_lock_loss_cnt <= w_lock_loss_next;
      r_dout          <= w_dout_next;
      r_dout_valid    <= w_dout_valid_next;
      r_comma_det     <= w_comma_det_next;
      r_sync_ready    <= (w_state_next == ST_LOCKED);
    end
  end

  assign o_dout          = r_dout;
  assign o_dout_valid    = r_dout_valid;
  assign o_sync_ready    = r_sync_ready;
  assign o_align_pos     = r_align_pos;
  assign o_comma_det     = r_comma_det;
  assign o_lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: doc/rx_comma_align.md
# rx_comma_align

Word-alignment stage for one Timepix3 8b/10b serial link, in the WCLK domain. It takes unaligned 10-bit parallel words from the deserializer and locates the K28.5 comma, then barrel-shifts the stream onto symbol boundaries. It declares sync after repeated commas at the same offset and drops sync on sustained decoder errors. Its outputs feed the 8b/10b decoder and byte-assembly logic of the receiver: `dout` goes to the decoder and `sync_ready` gates symbol writes. The decoder's `code_err | disp_err` is returned on `code_err`.

## Interface
- COMMA_LOCK_CNT, 4: number of commas at the same offset needed to enter LOCKED (range 2..15).
- ERR_UNLOCK_CNT, 8: number of qualified decoder errors in LOCKED, without an intervening good comma, that forces HUNT (range 1..255).
- WCLK  in  1  word clock. All logic is clocked on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- din  in  10  raw deserializer word; din[0] is the earliest received bit.
- din_valid  in  1  din carries a new word this cycle.
- code_err  in  1  decoder error for the word currently on dout. Sampled only when dout_valid=1.
- dout  out  10  aligned symbol; dout[0] is the earliest bit (bit a).
- dout_valid  out  1  dout holds a new aligned symbol and the block is LOCKED.
- sync_ready  out  1  block is in LOCKED.
- align_pos  out  4  bit offset in use (0..9).
- comma_det  out  1  registered pulse: a comma was found at align_pos in the word now on dout.
- lock_loss_cnt  out  8  saturating count of LOCKED→HUNT transitions.

## Operation
- Window: w[19:0] = {din, prev}. `prev` is the last din accepted with din_valid=1; it resets to 0.
- Comma match at offset k (0..9):
  - w[k+6:k] = 7'b1111100, i.e. bits a..g = 0011111 (RD−), or
  - w[k+6:k] = 7'b0000011, i.e. bits a..g = 1100000 (RD+).
- If several offsets match in one word, the lowest k wins.
- Aligned word: w[k+9:k], where k = align_pos.
- Cycles with din_valid=0 change nothing: no state, counter, prev or output update. dout_valid and comma_det are 0 on those cycles.
- States: HUNT (reset state), VERIFY, LOCKED. Transitions are evaluated only on din_valid=1 cycles.
  - **HUNT:** on a comma at any offset k: align_pos←k, hit_cnt←1, go to VERIFY. Otherwise stay.
  - **VERIFY:**
    - Comma at align_pos: hit_cnt+1. When hit_cnt+1 = COMMA_LOCK_CNT, go to LOCKED and clear err_cnt.
    - Comma at a different offset j: align_pos←j, hit_cnt←1, stay in VERIFY.
    - Non-comma word: no change.
  - **LOCKED:** align_pos is frozen.
    - A comma at align_pos clears err_cnt.
    - A comma at any other offset counts as an error.
    - code_err=1 while dout_valid=1 counts as an error.
    - If both error sources occur in the same cycle, they count once.
    - When err_cnt reaches ERR_UNLOCK_CNT: go to HUNT, align_pos←0, increment lock_loss_cnt (saturates at 255).
- dout is updated on every din_valid cycle using the current align_pos, also in HUNT and VERIFY. dout_valid is asserted only in LOCKED.
- Counter widths: hit_cnt is 4 bits; err_cnt is 8 bits. Neither counter wraps.

## Timing
- Reset values (RESET sampled high at an edge):
  - state=HUNT; sync_ready=0; align_pos=0; dout=0; dout_valid=0; comma_det=0.
  - lock_loss_cnt=0; err_cnt=0; hit_cnt=0; prev=0.
- All outputs are registered. Latency from din to dout is 1 WCLK.
- Lock timing: the din word that completes the COMMA_LOCK_CNT-th comma is sampled at edge N. After edge N:
  - sync_ready=1 and dout_valid=1;
  - dout holds that comma symbol and comma_det=1.
- Unlock timing: the ERR_UNLOCK_CNT-th error is sampled at edge N. After edge N, sync_ready=0 and dout_valid=0. No further symbols are delivered.
- code_err is combinational from dout, via the decoder. It is evaluated at the same edge that loads the next dout.
- RESET in mid-lock takes effect at the next edge and overrides din_valid.

## Test plan
- Lock at offset 3:
  - Stimulus: stream K28.5 (RD−/RD+ alternating) shifted by 3 bits, din_valid=1 every cycle.
  - Required: sync_ready rises after the 4th comma; align_pos=3; dout=K28.5 with comma_det=1; subsequent D-symbols delivered unshifted.
- Offset change in VERIFY:
  - Stimulus: 2 commas at offset 3, then commas at offset 7.
  - Required: align_pos=7; lock occurs only after 4 commas at offset 7; sync_ready stays 0 until then.
- Error unlock:
  - Stimulus: while LOCKED, force code_err=1 for 8 valid words.
  - Required: sync_ready=0 after the 8th; lock_loss_cnt=1; align_pos=0. Repeating 300 times leaves lock_loss_cnt=255.
- Error clear by comma:
  - Stimulus: while LOCKED, 7 errors, then a comma at align_pos, then 7 errors.
  - Required: still LOCKED.
- din_valid gaps:
  - Stimulus: lock sequence with din_valid=0 inserted every other cycle.
  - Required: same lock result as the gap-free case; dout_valid=0 on gap cycles; prev is not corrupted.
- Reset mid-lock:
  - Stimulus: assert RESET for 1 cycle while LOCKED.
  - Required: next cycle, all outputs are at their reset values and state is HUNT. Relock takes exactly 4 commas.
